param_rom: RTL



---
 rtl/param_rom_pkg.sv | 30 +++
 rtl/param_rom_if.sv | 36 +++
 rtl/rom_pipe_stage.sv | 21 ++
 rtl/param_rom.sv | 89 ++++++++
 4 files changed

// File: rtl/param_rom_pkg.sv
// Shared types and helpers for the parametrised pipelined ROM.
// ROM_PARITY_EN adds a stored parity bit to every pipeline stage.
package rom_pkg;

  localparam int LAT_MAX    = 4;
  localparam int DATA_W_MAX = 64;

  typedef struct packed {
    logic                  vld;
    logic                  err;
`ifdef ROM_PARITY_EN
    logic                  par;
`endif
    logic [DATA_W_MAX-1:0] data;
  } rom_stage_t;

  // (base + idx) wrapped to the low `width` bits.
  function automatic logic [DATA_W_MAX-1:0] rom_init_word(
    input logic [31:0] base,
    input int unsigned idx,
    input int unsigned width
  );
    logic [DATA_W_MAX-1:0] sum;
    logic [DATA_W_MAX-1:0] mask;
    sum  = DATA_W_MAX'(base) + DATA_W_MAX'(idx);
    mask = (width >= DATA_W_MAX) ? '1 : ((DATA_W_MAX'(1) << width) - DATA_W_MAX'(1));
    return sum & mask;
  endfunction

endpackage

// File: rtl/param_rom_if.sv
// Request/response handshake bundle for param_rom.
// ROM_PARITY_EN adds par_inject (request side) and rsp_par_err (response side).
interface param_rom_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
`ifdef ROM_PARITY_EN
  logic              par_inject;
  logic              rsp_par_err;

  modport master (
    output req_valid, req_addr, rsp_ready, par_inject,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_par_err
  );
  modport slave (
    input  req_valid, req_addr, rsp_ready, par_inject,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_par_err
  );
`else
  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );
  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
`endif
endinterface

// File: rtl/rom_pipe_stage.sv
// One holding register of the ROM read pipeline; loads only when the pipe advances.
module rom_pipe_stage
  import rom_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  rom_stage_t stage_next,
  output rom_stage_t stage_reg
);

  // The whole stage is cleared so rsp_data/rsp_err read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else if (en) begin
      stage_reg <= stage_next;
    end
  end

endmodule

// File: rtl/param_rom.sv
// Parametrised ROM (word i = INIT_BASE + i) behind a LATENCY-deep, globally stalled pipeline.
// ROM_PARITY_EN stores an even-parity bit per word and checks it in the last stage.
module param_rom
  import rom_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] INIT_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  param_rom_if.slave  bus
);

  logic [DATA_W-1:0] rom_mem [DEPTH];
`ifdef ROM_PARITY_EN
  logic              par_mem [DEPTH];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_init
      localparam logic [DATA_W-1:0] WORD = DATA_W'(rom_init_word(INIT_BASE, gi, DATA_W));
      assign rom_mem[gi] = WORD;
`ifdef ROM_PARITY_EN
      assign par_mem[gi] = ^WORD;
`endif
    end
  endgenerate

  rom_stage_t        head_next;
  rom_stage_t        stage_in [LATENCY];
  rom_stage_t        stage_q  [LATENCY];
  rom_stage_t        tail;
  logic              stall;
  logic              accept;
  logic              addr_ok;
  logic [ADDR_W-1:0] rd_idx;
  logic              unused_hi;

  assign tail    = stage_q[LATENCY-1];
  assign stall   = tail.vld && !bus.rsp_ready;
  assign accept  = bus.req_valid && !stall;
  assign addr_ok = 32'(bus.req_addr) < 32'(DEPTH);
  // Out-of-range addresses never reach the array index.
  assign rd_idx  = addr_ok ? bus.req_addr : '0;

  always_comb begin
    head_next      = '0;
    head_next.vld  = accept;
    head_next.err  = !addr_ok;
    head_next.data = addr_ok ? DATA_W_MAX'(rom_mem[rd_idx]) : '0;
`ifdef ROM_PARITY_EN
    head_next.par  = addr_ok ? (par_mem[rd_idx] ^ bus.par_inject) : 1'b0;
`endif
  end

  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_in[gi] = head_next;
      end else begin : g_chain
        assign stage_in[gi] = stage_q[gi-1];
      end

      rom_pipe_stage u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (!stall),
        .stage_next (stage_in[gi]),
        .stage_reg  (stage_q[gi])
      );
    end
  endgenerate

  assign bus.req_ready = !stall;
  assign bus.rsp_valid = tail.vld;
  assign bus.rsp_err   = tail.err;
  assign bus.rsp_data  = tail.data[DATA_W-1:0];
  // Bits above DATA_W are always zero; folded here so they do not dangle.
  assign unused_hi     = ^tail.data;

`ifdef ROM_PARITY_EN
  assign bus.rsp_par_err = tail.vld && !tail.err && ((^tail.data[DATA_W-1:0]) != tail.par);
`endif

endmodule
